inference_uart_tx: RTL and testbench

Downstream consumer of the CPU's inference port. It captures each `inference_out` frame on `inference_valid_out` into a small frame FIFO. It then serializes each frame, byte by byte, as 8N1 UART so a host can read inferences and weights (`OUTPUT_W`) off the FPGA. Frame capture never stalls the CPU; frames that arrive while the FIFO is full are dropped and flagged.

---
 rtl/inference_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_inference_uart_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_uart_tx.sv
// Buffers CPU inference frames in a small FIFO and serializes each one as 8N1 UART:
// an optional sync byte first, then the frame bytes, least-significant byte first.
module inference_uart_tx #(
    parameter int         X_SIZE      = 512,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         BAUD_DIV    = 868,
    parameter int         SYNC_ENABLE = 1,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic [X_SIZE-1:0]               inference_in,
    input  logic                            inference_valid_in,
    output logic                            tx_out,
    output logic                            busy_out,
    output logic                            overflow_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] frames_pending_out
);
    localparam int NUM_BYTES   = X_SIZE / 8;
    localparam int TOTAL_BYTES = NUM_BYTES + ((SYNC_ENABLE != 0) ? 1 : 0);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BYTE_W      = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [X_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic [1:0]        r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_byte_idx;
    logic [X_SIZE-1:0] r_frame_q;
    logic              r_tx;

    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_baud_wrap;
    logic              w_sync_slot;
    logic              w_last_byte;
    logic [7:0]        w_cur_byte;
    logic              w_next_bit;

    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push      = inference_valid_in && (!w_full || w_pop);
    assign w_baud_wrap = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));
    assign w_sync_slot = (SYNC_ENABLE != 0) && (r_byte_idx == '0);
    assign w_last_byte = (r_byte_idx == BYTE_W'(TOTAL_BYTES - 1));
    assign w_cur_byte  = w_sync_slot ? SYNC_BYTE : r_frame_q[7:0];
    assign w_next_bit  = w_cur_byte[r_bit_idx + 3'd1];

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= inference_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (inference_valid_in && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || r_state == S_IDLE || w_baud_wrap) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // r_tx is registered from the next-state decision so the line changes on the transition edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_frame_q  <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame_q  <= r_mem[r_rd_ptr];
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_next_bit;
                        end
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        if (w_last_byte) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                            if (!w_sync_slot) begin
                                r_frame_q <= r_frame_q >> 8;
                            end
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_out             = r_tx;
    assign busy_out           = (r_state != S_IDLE);
    assign overflow_out       = r_overflow;
    assign frames_pending_out = r_count;

endmodule

// File: tb/tb_inference_uart_tx.sv
// Randomized self-checking bench for inference_uart_tx: a UART line decoder and a
// frame/byte-queue reference model predict every byte, count and flag.
module tb_inference_uart_tx;
    localparam int B0 = 4;
    localparam int B7 = 7;

    typedef int intq_t[$];

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        valid;
    logic        tx;
    logic        busy;
    logic        ovf;
    logic [1:0]  pend;
    logic [15:0] data7;
    logic        valid7;
    logic        tx7;
    logic        busy7;
    logic        ovf7;
    logic [1:0]  pend7;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          m_count;
    bit          m_ovf;
    int          mon_err = 0;

    inference_uart_tx #(
        .X_SIZE(16), .FIFO_DEPTH(2), .BAUD_DIV(B0), .SYNC_ENABLE(1), .SYNC_BYTE(8'hA5)
    ) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .inference_in(data), .inference_valid_in(valid),
        .tx_out(tx), .busy_out(busy), .overflow_out(ovf), .frames_pending_out(pend)
    );

    inference_uart_tx #(
        .X_SIZE(16), .FIFO_DEPTH(2), .BAUD_DIV(B7), .SYNC_ENABLE(1), .SYNC_BYTE(8'hA5)
    ) u_dut7 (
        .clk_in(clk), .rst_n_in(rst_n), .inference_in(data7), .inference_valid_in(valid7),
        .tx_out(tx7), .busy_out(busy7), .overflow_out(ovf7), .frames_pending_out(pend7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1, "watchdog");
    end

    // UART decoder on the BAUD_DIV=4 line: samples each bit mid-cell at the negedge.
    bit         mon_active;
    int         mon_cnt;
    logic [7:0] mon_sh;
    initial begin
        mon_active = 0;
        mon_cnt    = 0;
        mon_sh     = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_active = 0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if ((mon_cnt % B0) == (B0 / 2) && mon_cnt > B0) begin
                    if (mon_cnt / B0 <= 8) begin
                        mon_sh[mon_cnt / B0 - 1] = tx;
                    end else begin
                        if (tx !== 1'b1) mon_err++;
                        rx_q.push_back(mon_sh);
                        mon_active = 0;
                    end
                end
            end
        end
    end

    function automatic bit m_push(input logic [15:0] f, input bit pop_same);
        if (m_count < 2 || pop_same) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(f[7:0]);
            exp_q.push_back(f[15:8]);
            m_count++;
            return 1'b1;
        end
        m_ovf = 1'b1;
        return 1'b0;
    endfunction

    function automatic intq_t run_lengths(input bit s[$]);
        intq_t r;
        int    len = 1;
        for (int i = 1; i < s.size(); i++) begin
            if (s[i] == s[i-1]) begin
                len++;
            end else begin
                r.push_back(len);
                len = 1;
            end
        end
        r.push_back(len);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        valid  = 1'b0;
        valid7 = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < max_cyc; k++) begin
            tick;
            if (busy === 1'b0 && pend === 2'd0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (4) tick;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_checks++; if (pend !== 2'd0) begin n_fail++; $display("FAIL rst_pend: got %0d want 0", pend); end
        n_checks++; if (tx7 !== 1'b1 || busy7 !== 1'b0) begin n_fail++; $display("FAIL rst_dut7: got tx=%b busy=%b want 1/0", tx7, busy7); end
    endtask

    task automatic test_single;
        logic [7:0] bytes [3];
        bit         wave[$];
        bytes = '{8'hA5, 8'h34, 8'h12};
        do_reset;
        for (int b = 0; b < 3; b++) begin
            repeat (B0) wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (B0) wave.push_back(bytes[b][i]);
            repeat (B0) wave.push_back(1'b1);
        end
        data = 16'h1234; valid = 1'b1;
        tick;
        valid = 1'b0;
        n_checks++; if (pend !== 2'd1) begin n_fail++; $display("FAIL single_pend_push: got %0d want 1", pend); end
        n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_pre_pop: got tx=%b busy=%b want 1/0", tx, busy); end
        for (int k = 0; k < wave.size(); k++) begin
            tick;
            n_checks++; if (tx !== wave[k]) begin n_fail++; $display("FAIL single_wave[%0d]: got %b want %b", k, tx, wave[k]); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want 1", k, busy); end
        end
        n_checks++; if (pend !== 2'd0) begin n_fail++; $display("FAIL single_pend_end: got %0d want 0", pend); end
        tick;
        n_checks++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL single_end: got busy=%b tx=%b want 0/1", busy, tx); end
        repeat (3) tick;
        n_checks++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL single_rx_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== bytes[i]) begin n_fail++; $display("FAIL single_rx[%0d]: got %h want %h", i, rx_q[i], bytes[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        bit acc;
        do_reset;
        data = 16'h00FF; valid = 1'b1;
        tick;
        acc = m_push(16'h00FF, 1'b0);
        n_checks++; if (pend !== 2'd1) begin n_fail++; $display("FAIL b2b_pend_a: got %0d want 1", pend); end
        data = 16'hFF00;
        tick;
        valid = 1'b0;
        acc = m_push(16'hFF00, 1'b1);
        m_count--;
        n_checks++; if (pend !== 2'(m_count)) begin n_fail++; $display("FAIL b2b_pend_b: got %0d want %0d", pend, m_count); end
        n_checks++; if (busy !== 1'b1 || tx !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got busy=%b tx=%b want 1/0", busy, tx); end
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick;
            if (busy === 1'b0) begin to = 1'b0; break; end
        end
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_first_done: busy still %b after 300 cycles, want 0", busy); end
        tick;
        m_count--;
        n_checks++; if (busy !== 1'b1 || pend !== 2'(m_count)) begin n_fail++; $display("FAIL b2b_second_pop: got busy=%b pend=%0d want 1/%0d", busy, pend, m_count); end
        wait_drain(500, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: timed out, want idle"); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow;
        bit          to;
        bit          acc;
        logic [15:0] f1;
        do_reset;
        f1 = 16'($urandom);
        data = f1; valid = 1'b1;
        tick;
        valid = 1'b0;
        acc = m_push(f1, 1'b0);
        tick;
        m_count--;
        repeat (3) tick;
        for (int i = 1; i <= 3; i++) begin
            data = 16'(i); valid = 1'b1;
            tick;
            valid = 1'b0;
            acc = m_push(16'(i), 1'b0);
            n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, ovf, m_ovf); end
            n_checks++; if (pend !== 2'(m_count)) begin n_fail++; $display("FAIL ovf_pend[%0d]: got %0d want %0d", i, pend, m_count); end
            repeat (4) tick;
        end
        wait_drain(1000, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: timed out, want idle"); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_pop;
        bit          to;
        bit          acc;
        logic [15:0] f [4];
        do_reset;
        for (int i = 0; i < 4; i++) f[i] = 16'($urandom);
        data = f[0]; valid = 1'b1;
        tick;
        valid = 1'b0;
        acc = m_push(f[0], 1'b0);
        tick;
        m_count--;
        data = f[1]; valid = 1'b1;
        tick;
        acc = m_push(f[1], 1'b0);
        data = f[2];
        tick;
        valid = 1'b0;
        acc = m_push(f[2], 1'b0);
        n_checks++; if (pend !== 2'd2) begin n_fail++; $display("FAIL full_pend_pre: got %0d want 2", pend); end
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick;
            if (busy === 1'b0) begin to = 1'b0; break; end
        end
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_first_done: busy still %b after 300 cycles, want 0", busy); end
        data = f[3]; valid = 1'b1;
        tick;
        valid = 1'b0;
        acc = m_push(f[3], 1'b1);
        m_count--;
        n_checks++; if (pend !== 2'(m_count)) begin n_fail++; $display("FAIL full_pend_pop: got %0d want %0d", pend, m_count); end
        n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL full_ovf: got %b want %b", ovf, m_ovf); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", busy); end
        wait_drain(1500, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_drain: timed out, want idle"); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit          to;
        bit          acc;
        logic [15:0] x;
        logic [15:0] y;
        do_reset;
        x = 16'($urandom);
        y = 16'($urandom);
        data = x; valid = 1'b1;
        tick;
        valid = 1'b0;
        acc = m_push(x, 1'b0);
        repeat (51) tick;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (pend !== 2'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got pend=%0d ovf=%b want 0/0", pend, ovf); end
        exp_q.delete();
        rx_q.delete();
        m_count = 0;
        repeat (3) tick;
        data = y; valid = 1'b1;
        tick;
        valid = 1'b0;
        acc = m_push(y, 1'b0);
        wait_drain(500, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: timed out, want idle"); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rmid_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_baud;
        logic [7:0] bytes [3];
        bit         want[$];
        bit         got[$];
        intq_t      r_want;
        intq_t      r_got;
        bytes = '{8'hA5, 8'h01, 8'h80};
        do_reset;
        for (int b = 0; b < 3; b++) begin
            repeat (B7) want.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (B7) want.push_back(bytes[b][i]);
            repeat (B7) want.push_back(1'b1);
        end
        data7 = 16'h8001; valid7 = 1'b1;
        tick;
        valid7 = 1'b0;
        for (int k = 0; k < want.size(); k++) begin
            tick;
            got.push_back(tx7);
        end
        tick;
        n_checks++; if (busy7 !== 1'b0) begin n_fail++; $display("FAIL baud_end_busy: got %b want 0", busy7); end
        r_want = run_lengths(want);
        r_got  = run_lengths(got);
        n_checks++; if (r_got.size() !== r_want.size()) begin n_fail++; $display("FAIL baud_run_count: got %0d want %0d", r_got.size(), r_want.size()); end
        for (int i = 0; i < r_want.size() && i < r_got.size(); i++) begin
            n_checks++; if (r_got[i] !== r_want[i]) begin n_fail++; $display("FAIL baud_run[%0d]: got %0d want %0d", i, r_got[i], r_want[i]); end
            n_checks++; if ((r_got[i] % B7) !== 0) begin n_fail++; $display("FAIL baud_run_mult[%0d]: got %0d want multiple of %0d", i, r_got[i], B7); end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        valid7 = 1'b0;
        data   = '0;
        data7  = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_full_pop;
        test_reset_mid;
        test_baud;
        n_checks++; if (mon_err !== 0) begin n_fail++; $display("FAIL stop_bits: got %0d framing errors want 0", mon_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
